// File: rtl/cim_sequencer.sv
// Host-side sequencer for the CIM macro: buffers operands, launches a compute, captures results.
// Optional build macro CIM_SEQ_TIMEOUT_EN adds a RUN watchdog that forces an error result.
module cim_sequencer #(
  parameter int N_LANES     = 36,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic                            ld_sel,
  input  logic [5:0]                      ld_idx,
  input  logic [7:0]                      ld_data,
  input  logic [3:0]                      ld_wsign,
  input  logic                            cfg_infp,
  input  logic [4:0]                      cfg_wexp,
  input  logic                            cfg_keep_w,
  input  logic                            start,
  output logic                            err_incomplete,
  output logic                            busy,
  output logic                            InFp,
  output logic                            DataValid,
  output logic [0:N_LANES-1][7:0]         DataIn,
  output logic [0:N_LANES-1][7:0]         W,
  output logic [0:N_LANES-1][3:0]         W_sign,
  output logic [4:0]                      W_exp,
  input  logic                            CIM_done,
  input  logic signed [21:0]              FinalOut_INT,
  input  logic [7:0]                      FinalOut_FP0,
  input  logic [7:0]                      FinalOut_FP1,
  input  logic [7:0]                      FinalOut_FP2,
  input  logic [7:0]                      FinalOut_FP3,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic signed [21:0]              res_int,
  output logic [31:0]                     res_fp,
  output logic                            res_err
);

  // state | meaning
  // IDLE  | accept operand loads, wait for start with both masks full
  // ARM   | operands frozen, wait for CIM_done low so DataValid rises cleanly
  // RUN   | DataValid high, wait for CIM_done (or watchdog)
  // DONE  | result presented, wait for res_ready handshake
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [5:0] LANE_LIM = 6'(N_LANES);

  state_t               state;
  logic [N_LANES-1:0]   act_m;
  logic [N_LANES-1:0]   w_m;
  logic [0:N_LANES-1][7:0] act_q;
  logic [0:N_LANES-1][7:0] w_q;
  logic [0:N_LANES-1][3:0] ws_q;
  logic                 lane_ok;
  logic                 ld_fire;

`ifdef CIM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] run_cnt;
  logic             res_err_q;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign ld_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign lane_ok  = (ld_idx < LANE_LIM);
  assign ld_fire  = ld_valid && ld_ready && lane_ok;

  assign DataIn = act_q;
  assign W      = w_q;
  assign W_sign = ws_q;

  // Operand buffers need no reset; validity is tracked by the masks.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (ld_sel) begin
        w_q[ld_idx]  <= ld_data;
        ws_q[ld_idx] <= ld_wsign;
      end else begin
        act_q[ld_idx] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state          <= S_IDLE;
      DataValid      <= 1'b0;
      res_valid      <= 1'b0;
      res_int        <= '0;
      res_fp         <= '0;
      err_incomplete <= 1'b0;
      act_m          <= '0;
      w_m            <= '0;
      InFp           <= 1'b0;
      W_exp          <= '0;
`ifdef CIM_SEQ_TIMEOUT_EN
      run_cnt        <= '0;
      res_err_q      <= 1'b0;
`endif
    end else begin
      err_incomplete <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_fire) begin
            if (ld_sel) w_m[ld_idx]   <= 1'b1;
            else        act_m[ld_idx] <= 1'b1;
          end
          // start sees the masks as they stood before this cycle's load
          if (start) begin
            if ((&act_m) && (&w_m)) begin
              InFp  <= cfg_infp;
              W_exp <= cfg_wexp;
              state <= S_ARM;
            end else begin
              err_incomplete <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (!CIM_done) begin
            DataValid <= 1'b1;
            state     <= S_RUN;
`ifdef CIM_SEQ_TIMEOUT_EN
            run_cnt   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (CIM_done) begin
            res_int   <= FinalOut_INT;
            res_fp    <= {FinalOut_FP3, FinalOut_FP2, FinalOut_FP1, FinalOut_FP0};
            DataValid <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_DONE;
`ifdef CIM_SEQ_TIMEOUT_EN
            res_err_q <= 1'b0;
`endif
          end
`ifdef CIM_SEQ_TIMEOUT_EN
          else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            res_int   <= '0;
            res_fp    <= '0;
            res_err_q <= 1'b1;
            DataValid <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            act_m     <= '0;
            if (!cfg_keep_w) w_m <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
